// File: rtl/bram_stream_reader.sv
// bram_stream_reader: reads i_len words from a simple-dual-port RAM
// starting at i_base_addr and presents them as a valid/ready stream.
// Ports: i_clk, i_rst (sync, active-high), i_go/i_base_addr/i_len
// (start request), o_bram_en/o_bram_addr/i_bram_dout (RAM read side),
// o_data/o_valid/i_ready (stream), o_busy, o_done (1-cycle pulse).
// Optional: define STREAM_LAST_EN to add o_last on the final word.
module bram_stream_reader #(
   parameter int RAM_WIDTH  = 8,
   parameter int RAM_DEPTH  = 128,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_go,
   input  logic [ADDR_WIDTH-1:0] i_base_addr,
   input  logic [ADDR_WIDTH:0]   i_len,
   output logic                  o_bram_en,
   output logic [ADDR_WIDTH-1:0] o_bram_addr,
   input  logic [RAM_WIDTH-1:0]  i_bram_dout,
   output logic [RAM_WIDTH-1:0]  o_data,
   output logic                  o_valid,
   input  logic                  i_ready,
`ifdef STREAM_LAST_EN
   output logic                  o_last,
`endif
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int CW = ADDR_WIDTH + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [CW-1:0]         len_q, len_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  infl_q, infl_d;
   logic [RAM_WIDTH-1:0]  mem_q [2];
   logic [RAM_WIDTH-1:0]  mem_d [2];
   logic                  wptr_q, wptr_d;
   logic                  rptr_q, rptr_d;
   logic [1:0]            count_q, count_d;
`ifdef STREAM_LAST_EN
   logic                  lmem_q [2];
   logic                  lmem_d [2];
   logic                  infl_last_q, infl_last_d;
`endif

   logic [1:0]    occ;
   logic          pop;
   logic          push;
   logic          issue;
   logic          last_issue;
   logic [CW-1:0] sum;

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      len_d    = len_q;
      mem_d    = mem_q;
      // occ counts words already stored plus the one returning this cycle
      occ      = count_q + 2'(infl_q);
      pop      = (count_q != 2'd0) && i_ready;
      push     = infl_q;
      // a slot frees up this cycle if the head is being popped
      issue    = (state_q == S_READ) &&
                 ((occ < 2'd2) || ((occ == 2'd2) && pop));
      last_issue = issue && ((cnt_q + CW'(1)) == len_q);
      infl_d   = issue;
      cnt_d    = cnt_q + CW'(issue);
      if (push) begin
         mem_d[wptr_q] = i_bram_dout;
      end
      wptr_d   = wptr_q ^ push;
      rptr_d   = rptr_q ^ pop;
      count_d  = count_q + 2'(push) - 2'(pop);
`ifdef STREAM_LAST_EN
      lmem_d      = lmem_q;
      infl_last_d = last_issue;
      if (push) begin
         lmem_d[wptr_q] = infl_last_q;
      end
`endif

      unique case (state_q)
         S_IDLE: begin
            if (i_go) begin
               base_d  = i_base_addr;
               len_d   = i_len;
               cnt_d   = '0;
               state_d = (i_len == '0) ? S_DONE : S_READ;
            end
         end
         S_READ: begin
            if (last_issue) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // finish once the last word leaves the FIFO this cycle
            if ((count_d == 2'd0) && !infl_q) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      sum = {1'b0, base_q} + cnt_q;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         base_q   <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         infl_q   <= 1'b0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wptr_q   <= 1'b0;
         rptr_q   <= 1'b0;
         count_q  <= '0;
`ifdef STREAM_LAST_EN
         lmem_q[0]   <= 1'b0;
         lmem_q[1]   <= 1'b0;
         infl_last_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         infl_q   <= infl_d;
         mem_q    <= mem_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
`ifdef STREAM_LAST_EN
         lmem_q      <= lmem_d;
         infl_last_q <= infl_last_d;
`endif
      end
   end

   assign o_bram_en   = issue;
   assign o_bram_addr = issue ? ADDR_WIDTH'(sum % RAM_DEPTH) : '0;
   assign o_data      = mem_q[rptr_q];
   assign o_valid     = (count_q != 2'd0);
   assign o_busy      = (state_q != S_IDLE);
   assign o_done      = (state_q == S_DONE);
`ifdef STREAM_LAST_EN
   assign o_last      = o_valid && lmem_q[rptr_q];
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: directed table-driven bench for the
// RAM-to-stream sequencer, with a behavioural registered-read RAM.
module tb_bram_stream_reader;

   logic       clk = 1'b0;
   logic       i_rst, i_go, i_ready;
   logic [6:0] i_base_addr;
   logic [7:0] i_len;
   logic       o_bram_en;
   logic [6:0] o_bram_addr;
   logic [7:0] i_bram_dout;
   logic [7:0] o_data;
   logic       o_valid, o_busy, o_done;
`ifdef STREAM_LAST_EN
   logic       o_last;
`endif

   always #5 clk = ~clk;

   bram_stream_reader dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_go        (i_go),
      .i_base_addr (i_base_addr),
      .i_len       (i_len),
      .o_bram_en   (o_bram_en),
      .o_bram_addr (o_bram_addr),
      .i_bram_dout (i_bram_dout),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
`ifdef STREAM_LAST_EN
      .o_last      (o_last),
`endif
      .o_busy      (o_busy),
      .o_done      (o_done)
   );

   logic [7:0] bram [128];
   initial begin
      for (int k = 0; k < 128; k++) bram[k] = 8'(k + 16);
      i_bram_dout = 8'h00;
   end
   always @(posedge clk) begin
      if (o_bram_en) i_bram_dout <= bram[o_bram_addr];
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // per-transfer observations
   logic [7:0] got [256];
   int got_n, en_n, first_v, done_c, done_n, busy_n;
   int stab_err, iss_err, addr_err, last_hs;
   int last_idx, last_n, last_err;

   task automatic run_xfer(input logic [6:0] b, input logic [7:0] l,
                           input logic [15:0] rp, input int go2);
      int issued, accepted, occ;
      logic pop, prev_stall;
      logic [7:0] prev_data;
      got_n = 0; en_n = 0; first_v = -1; done_c = -1; done_n = 0;
      busy_n = 0; stab_err = 0; iss_err = 0; addr_err = 0;
      last_hs = -1; last_idx = -1; last_n = 0; last_err = 0;
      issued = 0; accepted = 0; prev_stall = 1'b0; prev_data = '0;
      @(negedge clk);
      i_go = 1'b1; i_base_addr = b; i_len = l; i_ready = rp[0];
      @(posedge clk);
      for (int c = 1; c < 400; c++) begin
         @(negedge clk);
         i_go = (c == go2);
         if (c == go2) begin
            i_base_addr = 7'd50; i_len = 8'd3;
         end
         i_ready = rp[c % 16];
         #1;
         pop = o_valid && i_ready;
         if (prev_stall && (!o_valid || o_data != prev_data))
            stab_err++;
         occ = issued - accepted;
         if (o_bram_en) begin
            if (occ > 2 || (occ == 2 && !pop)) iss_err++;
            if (o_bram_addr != 7'(int'(b) + issued)) addr_err++;
            issued++; en_n++;
         end
         if (o_valid && first_v < 0) first_v = c;
`ifdef STREAM_LAST_EN
         if (o_last && !o_valid) last_err++;
         if (pop && o_last) begin
            last_idx = got_n; last_n++;
         end
`endif
         if (pop) begin
            if (got_n < 256) got[got_n] = o_data;
            got_n++; accepted++; last_hs = c;
         end
         if (o_busy) busy_n++;
         if (o_done) begin
            done_n++;
            if (done_c < 0) done_c = c;
         end
         prev_stall = o_valid && !i_ready;
         prev_data = o_data;
         if (done_c >= 0 && c >= done_c + 2) break;
      end
      i_go = 1'b0; i_ready = 1'b1;
   endtask

   typedef struct {
      logic [6:0]  base;
      logic [7:0]  len;
      logic [15:0] rp;
      int          go2;
      int          exp_first;
      int          exp_done;
   } vec_t;

   vec_t vecs [7];

   initial begin
      vecs[0] = '{7'd5,   8'd4,   16'hFFFF, 0, 3, 7};
      vecs[1] = '{7'd126, 8'd4,   16'hFFFF, 0, 3, 7};
      vecs[2] = '{7'd0,   8'd6,   16'h9999, 0, 3, -1};
      vecs[3] = '{7'd0,   8'd0,   16'hFFFF, 0, -1, 1};
      vecs[4] = '{7'd0,   8'd128, 16'hFFFF, 0, 3, 131};
      vecs[5] = '{7'd10,  8'd5,   16'hAAAA, 0, 3, -1};
      vecs[6] = '{7'd5,   8'd4,   16'hFFFF, 2, 3, 7};

      i_rst = 1'b1; i_go = 1'b0; i_ready = 1'b1;
      i_base_addr = '0; i_len = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_en", int'(o_bram_en), 0);
      chk("reset_valid", int'(o_valid), 0);
      chk("reset_busy", int'(o_busy), 0);
      chk("reset_done", int'(o_done), 0);
      chk("reset_data", int'(o_data), 0);
      @(negedge clk);
      i_rst = 1'b0;

      for (int v = 0; v < 7; v++) begin
         run_xfer(vecs[v].base, vecs[v].len, vecs[v].rp, vecs[v].go2);
         if (done_c < 0)
            chk($sformatf("v%0d_timeout", v), 1, 0);
         chk($sformatf("v%0d_words", v), got_n, int'(vecs[v].len));
         for (int i = 0; i < got_n && i < int'(vecs[v].len); i++)
            chk($sformatf("v%0d_data%0d", v, i), int'(got[i]),
                ((int'(vecs[v].base) + i) % 128) + 16);
         chk($sformatf("v%0d_en_cnt", v), en_n, int'(vecs[v].len));
         chk($sformatf("v%0d_addr", v), addr_err, 0);
         chk($sformatf("v%0d_issue_rule", v), iss_err, 0);
         chk($sformatf("v%0d_stable", v), stab_err, 0);
         chk($sformatf("v%0d_done_n", v), done_n, 1);
         chk($sformatf("v%0d_busy_n", v), busy_n, done_c);
         chk($sformatf("v%0d_first_v", v), first_v, vecs[v].exp_first);
         if (vecs[v].len != 0)
            chk($sformatf("v%0d_done_after_hs", v), done_c, last_hs + 1);
         if (vecs[v].exp_done >= 0)
            chk($sformatf("v%0d_done_c", v), done_c, vecs[v].exp_done);
`ifdef STREAM_LAST_EN
         chk($sformatf("v%0d_last_err", v), last_err, 0);
         chk($sformatf("v%0d_last_n", v), last_n,
             (vecs[v].len != 0) ? 1 : 0);
         chk($sformatf("v%0d_last_idx", v), last_idx,
             int'(vecs[v].len) - 1);
`endif
         repeat (2) @(negedge clk);
      end

      // reset in the middle of a len=8 transfer after two words
      @(negedge clk);
      i_go = 1'b1; i_base_addr = 7'd0; i_len = 8'd8; i_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_go = 1'b0;
      repeat (3) @(negedge clk);
      @(negedge clk);
      i_rst = 1'b1;
      @(negedge clk);
      i_rst = 1'b0;
      #1;
      chk("rst_mid_en", int'(o_bram_en), 0);
      chk("rst_mid_addr", int'(o_bram_addr), 0);
      chk("rst_mid_valid", int'(o_valid), 0);
      chk("rst_mid_data", int'(o_data), 0);
      chk("rst_mid_busy", int'(o_busy), 0);
      chk("rst_mid_done", int'(o_done), 0);
      @(negedge clk);
      #1;
      chk("rst_mid_stale", int'(o_valid), 0);
      run_xfer(7'd0, 8'd1, 16'hFFFF, 0);
      chk("after_rst_words", got_n, 1);
      chk("after_rst_data", int'(got[0]), 16);
      chk("after_rst_done_c", done_c, 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
